// File: rtl/bagging_pkg.sv
// Shared definitions for the bagging ensemble weight loader.
// Holds the memory geometry, the weight width and the loader state encoding.
// The same values are used by the loader, its address counter and the
// loader bus interface.
package bagging_pkg;

    localparam int N_MEM     = 3;                 // ensemble members / weight memories
    localparam int DEPTH     = 32;                // words per memory
    localparam int ADDR_W    = $clog2(DEPTH);     // 5
    localparam int WEIGHT_W  = 9;                 // signed weight width
    localparam int MEM_IDX_W = $clog2(N_MEM);     // member index width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_FIN,
        RUN,
        DONE
    } loader_state_t;

endpackage

// File: rtl/bagging_weight_loader_if.sv
// Bus between the weight loader and its environment.
// Carries the inbound weight stream (in_valid/in_ready/in_data) and the
// per-member weight-memory port (finish flags, write/read strobes, address
// and write data, all packed with slice i belonging to memory i).
//   master : the loader side (consumes the stream, drives the memories)
//   slave  : the host/DMA plus the memories
interface bagging_weight_loader_if;
    import bagging_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic signed [WEIGHT_W-1:0] in_data;
    logic [N_MEM-1:0]           mem_finish;
    logic [N_MEM-1:0]           mem_write;
    logic [N_MEM-1:0]           mem_read;
    logic [N_MEM*ADDR_W-1:0]    mem_addr;
    logic [N_MEM*WEIGHT_W-1:0]  mem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        input  mem_finish,
        output in_ready,
        output mem_write,
        output mem_read,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        output mem_finish,
        input  in_ready,
        input  mem_write,
        input  mem_read,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/bagging_addr_counter.sv
// Word address / member index counter.
// Counts addr 0..DEPTH-1; on wrap the member index advances, and after the
// last address of the last member both roll back to 0.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear to 0/0 (wins over inc)
//   inc      : advance by one word
//   addr     : word address within the current member
//   idx      : current member index
//   tc       : high while pointing at the very last word (last member, DEPTH-1)
module bagging_addr_counter
    import bagging_pkg::*;
#(
    parameter int N_IDX = N_MEM,
    parameter int IDX_W = (N_IDX > 1) ? $clog2(N_IDX) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_IDX - 1);

    logic addr_last;

    assign addr_last = (addr == ADDR_LAST);
    assign tc        = addr_last && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
            idx  <= '0;
        end else if (clr) begin
            addr <= '0;
            idx  <= '0;
        end else if (inc) begin
            if (addr_last) begin
                addr <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/bagging_weight_loader.sv
// Weight loader for the 3-member bagging ensemble.
// Takes one stream of N_MEM*DEPTH signed weights and scatters it into the
// member memories (word k -> memory k/DEPTH, address k%DEPTH), waits for all
// memories to report finish, then sweeps addresses 0..DEPTH-1 with read and
// en_out asserted so every classifier sees its weights in order.
//   clk, rst    : clock, asynchronous active-low reset
//   start       : launch a load+run sequence (only honoured in IDLE)
//   bus         : weight stream in, memory write/read/address/data out
//   en_out      : classifier enable, high during the read sweep
//   busy        : sequence in progress
//   done        : one-cycle pulse at the end of the read sweep
//   err         : sticky finish-timeout flag, cleared by the next start
module bagging_weight_loader
    import bagging_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    bagging_weight_loader_if.master bus,
    output logic                    en_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int              TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    loader_state_t state, state_nxt;

    logic                      vld_p0;      // stream handshake this cycle
    logic                      fin_all;
    logic                      load_full;   // last word taken, final strobe pending
    logic [ADDR_W-1:0]         ld_addr;
    logic [MEM_IDX_W-1:0]      ld_idx;
    logic                      ld_tc;
    logic [ADDR_W-1:0]         run_addr;
    logic                      run_tc;
    logic                      run_idx_unused; // sweep counter has a single member slot
    logic [TO_W-1:0]           tcnt;
    logic [N_MEM-1:0]          write_p1;
    logic [N_MEM*ADDR_W-1:0]   addr_p1;
    logic [N_MEM*WEIGHT_W-1:0] wdata_p1;

    assign vld_p0  = bus.in_valid && bus.in_ready;
    assign fin_all = &bus.mem_finish;

    // Scatter counter: advances once per accepted word, held at 0 while idle.
    bagging_addr_counter #(.N_IDX(N_MEM)) u_load_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .inc  (vld_p0),
        .addr (ld_addr),
        .idx  (ld_idx),
        .tc   (ld_tc)
    );

    // Sweep counter: starts at 0 on entry to RUN, one address per cycle.
    bagging_addr_counter #(.N_IDX(1)) u_run_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != RUN),
        .inc  (state == RUN),
        .addr (run_addr),
        .idx  (run_idx_unused),
        .tc   (run_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.mem_read  = '0;
        bus.mem_addr  = addr_p1;
        en_out        = 1'b0;
        busy          = (state != IDLE);
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                // Stay one extra cycle after the last word so its strobe
                // goes out while still in LOAD.
                bus.in_ready = !load_full;
                if (load_full) state_nxt = WAIT_FIN;
            end
            WAIT_FIN: begin
                if (fin_all)               state_nxt = RUN;
                else if (tcnt == TO_LAST)  state_nxt = IDLE;
            end
            RUN: begin
                bus.mem_read = '1;
                bus.mem_addr = {N_MEM{run_addr}};
                en_out       = 1'b1;
                if (run_tc) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: accepted word becomes a one-cycle write to its member;
    // address and data slices hold between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_p1  <= '0;
            addr_p1   <= '0;
            wdata_p1  <= '0;
            load_full <= 1'b0;
            tcnt      <= '0;
            err       <= 1'b0;
        end else begin
            write_p1 <= '0;
            if (vld_p0) begin
                for (int i = 0; i < N_MEM; i++) begin
                    if (ld_idx == MEM_IDX_W'(i)) begin
                        write_p1[i]                      <= 1'b1;
                        addr_p1[i*ADDR_W +: ADDR_W]      <= ld_addr;
                        wdata_p1[i*WEIGHT_W +: WEIGHT_W] <= bus.in_data;
                    end
                end
            end
            load_full <= (state_nxt == LOAD) && (load_full || (vld_p0 && ld_tc));
            tcnt      <= (state == WAIT_FIN) ? tcnt + TO_W'(1) : '0;
            if (state == IDLE && start) begin
                err <= 1'b0;
            end else if (state == WAIT_FIN && !fin_all && tcnt == TO_LAST) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.mem_write = write_p1;
    assign bus.mem_wdata = wdata_p1;

endmodule

// File: tb/tb_bagging_weight_loader.sv
// Directed bench for bagging_weight_loader: reset values, stream scatter,
// gapped stream, ignored start pulses, finish timeout, mid-load reset and
// signed weight pass-through.
module tb_bagging_weight_loader;
    import bagging_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic en_out, busy, done, err;

    bagging_weight_loader_if bus ();

    bagging_weight_loader dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (bus),
        .en_out (en_out),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic signed [WEIGHT_W-1:0] stim [N_MEM*DEPTH];

    logic [N_MEM-1:0]          wr_we [1024];
    logic [N_MEM*ADDR_W-1:0]   wr_a  [1024];
    logic [N_MEM*WEIGHT_W-1:0] wr_d  [1024];
    int wr_n    = 0;
    int rd_n    = 0;
    int rd_err  = 0;
    int run_pos = 0;
    int coll    = 0;
    int done_n  = 0;

    // Observer: looks at each cycle 2 time units after the rising edge.
    always begin
        @(posedge clk);
        #2;
        if (bus.mem_write != '0 && wr_n < 1024) begin
            wr_we[wr_n] = bus.mem_write;
            wr_a[wr_n]  = bus.mem_addr;
            wr_d[wr_n]  = bus.mem_wdata;
            wr_n++;
        end
        if (bus.mem_write != '0 && bus.mem_read != '0) coll++;
        if (done) done_n++;
        if (bus.mem_read != '0) begin
            rd_n++;
            if (bus.mem_read != 3'b111 || !en_out ||
                bus.mem_addr != {N_MEM{ADDR_W'(run_pos)}}) rd_err++;
            run_pos++;
        end else begin
            run_pos = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_seq();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready,  0);
        chk({tag, "_mem_write"}, bus.mem_write, 0);
        chk({tag, "_mem_read"},  bus.mem_read,  0);
        chk({tag, "_mem_addr"},  bus.mem_addr,  0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_en_out"},    en_out,        0);
        chk({tag, "_busy"},      busy,          0);
        chk({tag, "_done"},      done,          0);
        chk({tag, "_err"},       err,           0);
    endtask

    // Offer words k0..n-1; optional 1/0 valid pattern and start pokes.
    task automatic feed(input int n, input bit toggle, input bit poke, input int k0);
        int k   = k0;
        int cyc = 0;
        while (k < n && cyc < 2000) begin
            bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.in_data  = bus.in_valid ? stim[k] : 9'sh0aa;
            start        = poke && (cyc % 7 == 3);
            if (bus.in_valid && bus.in_ready) k++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        chk("feed_accepted", k, n);
    endtask

    task automatic wait_done(input bit poke);
        int cyc = 0;
        while (!done && cyc < 600) begin
            start = poke && (bus.mem_read != '0);
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("done_read_low", bus.mem_read, 0);
        chk("done_en_low", en_out, 0);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic verify_log(input int base, input int n, input string tag);
        int errs = 0;
        for (int k = 0; k < n; k++) begin
            int m = k / DEPTH;
            if (wr_we[base+k] != (N_MEM'(1) << m) ||
                wr_a[base+k][m*ADDR_W +: ADDR_W] != ADDR_W'(k % DEPTH) ||
                wr_d[base+k][m*WEIGHT_W +: WEIGHT_W] != stim[k]) errs++;
        end
        chk({tag, "_count"}, wr_n - base, n);
        chk({tag, "_order"}, errs, 0);
    endtask

    initial begin
        int base, d0, r0;

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.mem_finish = '0;

        // Reset values
        tick(2);
        check_zero("reset");
        rst = 1'b1;
        tick(1);

        // Back-to-back stream 0..95, all memories finished
        for (int k = 0; k < N_MEM*DEPTH; k++) stim[k] = 9'(k);
        bus.mem_finish = 3'b111;
        base = wr_n; d0 = done_n; r0 = rd_n;
        start_seq();
        chk("load_busy", busy, 1);
        chk("load_ready", bus.in_ready, 1);
        feed(96, 1'b0, 1'b0, 0);
        chk("last_strobe_we", bus.mem_write, 3'b100);
        chk("last_strobe_addr2", bus.mem_addr[2*ADDR_W +: ADDR_W], 31);
        chk("last_strobe_data2", bus.mem_wdata[2*WEIGHT_W +: WEIGHT_W], 95);
        chk("ready_drops", bus.in_ready, 0);
        tick(1);
        chk("strobe_ends", bus.mem_write, 0);
        chk("wdata_holds", bus.mem_wdata[2*WEIGHT_W +: WEIGHT_W], 95);
        chk("word37_we", wr_we[base+37], 3'b010);
        chk("word37_addr1", wr_a[base+37][ADDR_W +: ADDR_W], 5);
        chk("word37_data1", wr_d[base+37][WEIGHT_W +: WEIGHT_W], 37);
        verify_log(base, 96, "b2b");
        wait_done(1'b0);
        chk("b2b_run_cycles", rd_n - r0, 32);
        chk("b2b_run_addr", rd_err, 0);
        chk("b2b_done_pulses", done_n - d0, 1);

        // Gapped stream: valid toggles every cycle, idle data must be ignored
        for (int k = 0; k < N_MEM*DEPTH; k++) stim[k] = 9'(95 - k);
        base = wr_n; d0 = done_n;
        start_seq();
        feed(96, 1'b1, 1'b0, 0);
        verify_log(base, 96, "gap");
        wait_done(1'b0);
        chk("gap_done_pulses", done_n - d0, 1);

        // start pulses during LOAD, RUN and DONE are ignored
        base = wr_n; d0 = done_n; r0 = rd_n;
        start_seq();
        feed(96, 1'b0, 1'b1, 0);
        wait_done(1'b1);
        tick(3);
        chk("poke_still_idle", busy, 0);
        verify_log(base, 96, "poke");
        chk("poke_run_cycles", rd_n - r0, 32);
        chk("poke_done_pulses", done_n - d0, 1);

        // Finish timeout: memory 2 never finishes
        bus.mem_finish = 3'b011;
        d0 = done_n; r0 = rd_n;
        start_seq();
        feed(96, 1'b0, 1'b0, 0);
        tick(1);
        chk("to_first_wait_busy", busy, 1);
        chk("to_first_wait_err", err, 0);
        tick(255);
        chk("to_last_wait_busy", busy, 1);
        chk("to_last_wait_err", err, 0);
        tick(1);
        chk("to_idle", busy, 0);
        chk("to_err_set", err, 1);
        chk("to_no_done", done_n - d0, 0);
        chk("to_no_read", rd_n - r0, 0);
        tick(2);
        chk("to_err_sticky", err, 1);
        start_seq();
        chk("to_err_cleared", err, 0);
        chk("to_restart_busy", busy, 1);

        // Reset after 40 words of the new load
        d0 = done_n;
        feed(40, 1'b0, 1'b0, 0);
        chk("pre_reset_we", bus.mem_write, 3'b010);
        rst = 1'b0;
        #1;
        check_zero("abort");
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("abort_no_done", done_n - d0, 0);

        // Signed extremes; also restarts from member 0 address 0 after the abort
        for (int k = 0; k < N_MEM*DEPTH; k++) begin
            case (k % 4)
                0:       stim[k] = -9'sd256;
                1:       stim[k] = -9'sd1;
                2:       stim[k] = 9'sd255;
                default: stim[k] = 9'(k - 48);
            endcase
        end
        bus.mem_finish = 3'b111;
        base = wr_n; d0 = done_n;
        start_seq();
        bus.in_valid = 1'b1;
        bus.in_data  = stim[0];
        chk("neg_ready", bus.in_ready, 1);
        tick(1);
        bus.in_valid = 1'b0;
        chk("neg_first_we", bus.mem_write, 3'b001);
        chk("neg_first_addr0", bus.mem_addr[0 +: ADDR_W], 0);
        chk("neg_first_data0", bus.mem_wdata[0 +: WEIGHT_W], 9'h100);
        tick(1);
        chk("neg_strobe_single", bus.mem_write, 0);
        chk("neg_data_hold", bus.mem_wdata[0 +: WEIGHT_W], 9'h100);
        feed(96, 1'b0, 1'b0, 1);
        chk("neg_minus1", wr_d[base+1][0 +: WEIGHT_W], 9'h1ff);
        chk("neg_plus255", wr_d[base+2][0 +: WEIGHT_W], 9'h0ff);
        chk("neg_word51", wr_d[base+51][WEIGHT_W +: WEIGHT_W], 9'h003);
        verify_log(base, 96, "neg");
        wait_done(1'b0);
        chk("neg_done_pulses", done_n - d0, 1);

        chk("no_write_read_overlap", coll, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
